instr_prefetch: RTL
===================

INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter DEPTH, 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter PC_STEP, 4, address increment between sequential fetches.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_s  input  1  asynchronous, active-low reset.
REQ-006 in_mem_en  output  1  instruction memory read enable.
REQ-007 in_mem_addr  output  32  instruction memory read address.
REQ-008 in_mem  input  32  read data, valid exactly one clk after an accepted in_mem_en.
REQ-009 redirect  input  1  core branch/jump; flushes the queue and restarts fetch.
REQ-010 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-011 instr_valid  output  1  queue head holds a valid instruction.
REQ-012 instr  output  32  queue head instruction word.
REQ-013 instr_pc  output  32  address the head instruction was fetched from.
REQ-014 instr_ready  input  1  core accepts the head; a transfer occurs when instr_valid=1 and instr_ready=1.

Function
REQ-015 FSM states: BOOT (first cycle after reset release, no fetch), RUN (normal fetch), FLUSH (one cycle after redirect, no fetch).
REQ-016 Transitions: BOOT->RUN unconditionally; RUN->FLUSH on redirect; FLUSH->RUN unless redirect, in which case stay in FLUSH; any state->FLUSH on redirect.
REQ-017 In RUN, in_mem_en=1 iff (occupancy + in-flight) < DEPTH and redirect=0; in_mem_addr=fetch_pc.
REQ-018 On each issued read, fetch_pc advances by PC_STEP, modulo 2^32 (0xFFFF_FFFC+4 wraps to 0).
REQ-019 A returning word is pushed with its fetch address one cycle after issue unless killed; fill latency from RUN entry to instr_valid=1 is 2 cycles.
REQ-020 Credit rule: push never occurs into a full queue; no data is ever dropped except by redirect.
REQ-021 Push and pop in the same cycle are both honoured; occupancy is unchanged.
REQ-022 instr, instr_pc, and instr_valid are driven from registered queue state only, with no combinational path from in_mem.
REQ-023 Redirect: at the next edge, the queue is emptied, any in-flight read is killed, and fetch_pc=redirect_pc.
REQ-024 A transfer in the same cycle as redirect completes, and the consumed entry is not re-presented.
REQ-025 While redirect=1, in_mem_en=0; the first fetch of redirect_pc is issued in the cycle after FLUSH.
REQ-026 Queue pointers wrap modulo DEPTH; full occurs at occupancy DEPTH, empty at 0.

Reset
REQ-027 On reset_s=0, asynchronously: state=BOOT, fetch_pc=RESET_PC, occupancy=0, pointers=0, in-flight/kill=0.
REQ-028 During reset: in_mem_en=0, in_mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-029 Reset asserted mid-fill discards all queued and in-flight data; after release, fetch resumes from RESET_PC.

Configuration
REQ-030 Macro PREFETCH_STATS_EN: when defined, adds outputs stat_redirects[15:0] and stat_empty_cycles[15:0].
REQ-031 stat_redirects counts redirect cycles; stat_empty_cycles counts RUN cycles with instr_valid=0.
REQ-032 Both counters saturate at 16'hFFFF and reset to 0.
REQ-033 When PREFETCH_STATS_EN is not defined, these ports and their logic are absent; all other behaviour is identical.

Verification
REQ-034 Reset release, instr_ready=1 held -> in_mem_addr 0,4,8,...; instr_valid rises on the 3rd edge after release; instr_pc sequence 0,4,8 with matching words.
REQ-035 instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 reads issued, then in_mem_en=0; occupancy 4; no loss once ready=1.
REQ-036 redirect=1 with redirect_pc=0x100 while 2 reads are in flight -> stale words never appear; next instr_pc=0x100; head held in the redirect cycle is consumed once.
REQ-037 fetch_pc=0xFFFF_FFF8, free run -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 reset_s pulsed low mid-run -> outputs match REQ-028 immediately (asynchronously); after release, first in_mem_addr=RESET_PC.
REQ-039 With PREFETCH_STATS_EN, 3 redirects and 5 empty RUN cycles -> stat_redirects=3, stat_empty_cycles=5.

Source files
------------

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: sequential fetch with one-cycle memory latency and redirect flush.
// Optional PREFETCH_STATS_EN adds saturating redirect / empty-cycle counters.
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset_s,
  output logic        in_mem_en,
  output logic [31:0] in_mem_addr,
  input  logic [31:0] in_mem,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0] stat_redirects,
  output logic [15:0] stat_empty_cycles
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);

  typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [31:0]       infl_pc_q, infl_pc_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       pcs_q  [DEPTH];

  logic              push;
  logic              pop;
  logic [CntW:0]     used;

  // A returning word is dropped if a redirect lands in its arrival cycle.
  assign push = inflight_q & ~redirect;
  assign pop  = instr_valid & instr_ready;
  assign used = {1'b0, count_q} + (CntW + 1)'(inflight_q);

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? data_q[rptr_q] : 32'h0;
  assign instr_pc    = instr_valid ? pcs_q[rptr_q]  : 32'h0;
  assign in_mem_addr = fetch_pc_q;

  always_comb begin
    in_mem_en = 1'b0;
    state_d   = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun: begin
        state_d   = StRun;
        in_mem_en = ~redirect & (used < DepthW);
      end
      StFlush: state_d = StRun;
      default: state_d = StBoot;
    endcase
    if (redirect) state_d = StFlush;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = in_mem_en;
    infl_pc_d  = fetch_pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
    end else begin
      if (in_mem_en) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_s) begin
    if (!reset_s) begin
      state_q    <= StBoot;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      infl_pc_q  <= 32'h0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      infl_pc_q  <= infl_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wptr_q] <= in_mem;
      pcs_q[wptr_q]  <= infl_pc_q;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [15:0] redirects_q, redirects_d;
  logic [15:0] empty_q, empty_d;

  always_comb begin
    redirects_d = redirects_q;
    empty_d     = empty_q;
    if (redirect && redirects_q != 16'hFFFF) redirects_d = redirects_q + 16'd1;
    if (state_q == StRun && !instr_valid && empty_q != 16'hFFFF) empty_d = empty_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_s) begin
    if (!reset_s) begin
      redirects_q <= 16'h0;
      empty_q     <= 16'h0;
    end else begin
      redirects_q <= redirects_d;
      empty_q     <= empty_d;
    end
  end

  assign stat_redirects    = redirects_q;
  assign stat_empty_cycles = empty_q;
`endif

endmodule
